// File: rtl/pdm_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pdm_seq_pkg : shared widths, FSM encoding and helpers for the PDM sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
package pdm_seq_pkg;

    localparam int LEVEL_W  = 5;
    localparam int DEPTH    = 8;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PERIOD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        WAIT = 2'd2
    } state_t;

    // A programmed period of 0 behaves as 1 (back-to-back strobes).
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? PERIOD_W'(1) : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pdm_seq_interval_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pdm_seq_interval_timer : one-cycle expire pulse P cycles after a load
// Revision               : 1.0
// ---------------------------------------------------------------------------
module pdm_seq_interval_timer
    import pdm_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_val,
    output logic                expire
);

    logic [PERIOD_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - PERIOD_W'(1);
        end
    end

    // High in the cycle before the edge that lies P edges after the load edge.
    assign expire = (r_cnt == PERIOD_W'(1));

endmodule
`default_nettype wire

// File: rtl/pdm_level_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pdm_level_sequencer : plays a programmed level table into a PDM, one strobe
//                       per step period, one-shot or looping
// Revision            : 1.0
// ---------------------------------------------------------------------------
module pdm_level_sequencer
    import pdm_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_addr,
    input  logic [LEVEL_W-1:0]  cfg_data,
    input  logic [PERIOD_W-1:0] period,
    input  logic [IDX_W-1:0]    last_idx,
    input  logic                loop_en,
    input  logic                start,
    input  logic                stop,
    output logic [LEVEL_W-1:0]  pdm_level,
    output logic                pdm_we,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    cur_idx
);

    state_t               r_state, w_state_nxt;
    logic [LEVEL_W-1:0]   r_table [DEPTH];
    logic [LEVEL_W-1:0]   r_level, w_level_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt, w_emit_idx;
    logic                 r_we, r_busy, r_done, w_done_nxt;
    logic                 w_emit, w_expire;
    logic [PERIOD_W-1:0]  w_period_eff;

    assign w_period_eff = eff_period(period);

    // The timer is armed on the same edge that issues a strobe, so P=1
    // expires during the strobe cycle itself and strobes run back to back.
    pdm_seq_interval_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_emit),
        .load_val (w_period_eff),
        .expire   (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_idx  = '0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_emit = 1'b1;
                end
            end
            EMIT, WAIT: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    if (r_idx < last_idx) begin
                        w_emit     = 1'b1;
                        w_emit_idx = r_idx + IDX_W'(1);
                    end else if (loop_en) begin
                        w_emit = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_emit) begin
            w_state_nxt = EMIT;
        end
        // Table read happens before this edge's write lands: old value wins.
        w_level_nxt = w_emit ? r_table[w_emit_idx] : r_level;
        w_idx_nxt   = w_emit ? w_emit_idx : r_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_level <= w_level_nxt;
            r_we    <= w_emit;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_we) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    assign pdm_level = r_level;
    assign pdm_we    = r_we;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cur_idx   = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_pdm_level_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pdm_level_sequencer : directed + randomized bench against a timeline model
// Revision               : 1.0
// ---------------------------------------------------------------------------
module tb_pdm_level_sequencer;
    import pdm_seq_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_addr;
    logic [LEVEL_W-1:0]  cfg_data;
    logic [PERIOD_W-1:0] period;
    logic [IDX_W-1:0]    last_idx;
    logic                loop_en;
    logic                start;
    logic                stop;
    logic [LEVEL_W-1:0]  pdm_level;
    logic                pdm_we;
    logic                busy;
    logic                done;
    logic [IDX_W-1:0]    cur_idx;

    always #5 clk = ~clk;

    pdm_level_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .period    (period),
        .last_idx  (last_idx),
        .loop_en   (loop_en),
        .start     (start),
        .stop      (stop),
        .pdm_level (pdm_level),
        .pdm_we    (pdm_we),
        .busy      (busy),
        .done      (done),
        .cur_idx   (cur_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: playing flag, current entry and cycles remaining until next step.
    int m_tab [DEPTH];
    int m_level, m_idx, m_rem;
    bit m_we, m_busy, m_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
        m_level = 0; m_idx = 0; m_rem = 0;
        m_we = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_emit(input int i);
        m_level = m_tab[i];
        m_idx   = i;
        m_we    = 1;
        m_busy  = 1;
        m_rem   = (period == 0) ? 1 : int'(period);
    endtask

    // One rising edge of the reference, using the inputs currently applied.
    task automatic model_edge();
        m_we   = 0;
        m_done = 0;
        if (m_busy) begin
            if (stop) begin
                m_busy = 0;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_idx < int'(last_idx)) model_emit(m_idx + 1);
                    else if (loop_en)           model_emit(0);
                    else begin
                        m_done = 1;
                        m_busy = 0;
                    end
                end
            end
        end else if (start && !stop) begin
            model_emit(0);
        end
        if (cfg_we) m_tab[cfg_addr] = int'(cfg_data);
    endtask

    task automatic check_outputs(input string ctx);
        check_val({ctx, ".pdm_we"},    32'(pdm_we),    32'(m_we));
        check_val({ctx, ".pdm_level"}, 32'(pdm_level), 32'(m_level));
        check_val({ctx, ".busy"},      32'(busy),      32'(m_busy));
        check_val({ctx, ".done"},      32'(done),      32'(m_done));
        check_val({ctx, ".cur_idx"},   32'(cur_idx),   32'(m_idx));
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ctx);
    endtask

    task automatic run(input string ctx, input int n);
        for (int i = 0; i < n; i++) step(ctx);
    endtask

    task automatic write_entry(input int a, input int d);
        cfg_we = 1; cfg_addr = IDX_W'(a); cfg_data = LEVEL_W'(d);
        step("wr");
        cfg_we = 0;
    endtask

    task automatic pulse_start(input string ctx);
        start = 1;
        step(ctx);
        start = 0;
    endtask

    task automatic quiesce();
        stop = 1;
        step("quiesce");
        stop = 0;
        run("quiesce", 2);
    endtask

    initial begin
        reset = 1; cfg_we = 0; cfg_addr = '0; cfg_data = '0; period = '0;
        last_idx = '0; loop_en = 0; start = 0; stop = 0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        reset = 0;
        run("idle", 2);

        // One-shot, period 64: strobes 64 apart, done 64 after the last.
        write_entry(0, 8'h08); write_entry(1, 8'h1A);
        write_entry(2, 8'h0F); write_entry(3, 8'h04);
        period = 64; last_idx = 3; loop_en = 0;
        pulse_start("oneshot");
        run("oneshot", 270);

        // Loop at period 2, then abort.
        period = 2; loop_en = 1;
        pulse_start("loop");
        run("loop", 8);
        stop = 1; step("loop_stop"); stop = 0;
        run("after_stop", 12);

        // Period 0 and 1, three entries: back-to-back strobes.
        last_idx = 2; loop_en = 0;
        period = 0; pulse_start("p0"); run("p0", 6);
        period = 1; pulse_start("p1"); run("p1", 6);

        // Rewrite entry 1 on the very edge it is emitted.
        period = 2; last_idx = 3; loop_en = 1;
        pulse_start("rbw");
        step("rbw");
        cfg_we = 1; cfg_addr = 1; cfg_data = 5'h11;
        step("rbw_wr");
        cfg_we = 0;
        run("rbw", 10);
        quiesce();

        // start+stop together stays idle; start while busy changes nothing.
        start = 1; stop = 1; step("startstop"); start = 0; stop = 0;
        run("startstop", 3);
        period = 3; loop_en = 0;
        pulse_start("busy_start");
        start = 1; run("busy_start", 14); start = 0;
        run("busy_start", 3);

        // Async reset between edges mid-wait, then replay the cleared table.
        period = 10; pulse_start("ares"); run("ares", 4);
        #3 reset = 1;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        reset = 0;
        period = 2; last_idx = 3; loop_en = 0;
        pulse_start("replay");
        run("replay", 10);

        // Randomized episodes.
        for (int e = 0; e < 30; e++) begin
            period   = PERIOD_W'($urandom_range(0, 6));
            last_idx = IDX_W'($urandom_range(0, DEPTH - 1));
            loop_en  = 1'($urandom_range(0, 1));
            for (int c = 0; c < 150; c++) begin
                cfg_we   = ($urandom_range(0, 9) == 0);
                cfg_addr = IDX_W'($urandom);
                cfg_data = LEVEL_W'($urandom);
                start    = ($urandom_range(0, 9) < 3);
                stop     = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 29) == 0) period   = PERIOD_W'($urandom_range(0, 6));
                if ($urandom_range(0, 29) == 0) last_idx = IDX_W'($urandom);
                if ($urandom_range(0, 29) == 0) loop_en  = ~loop_en;
                step("rand");
            end
            cfg_we = 0; start = 0;
            quiesce();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
